// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes, FSM states, lane width.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package lsu_pkg;

   localparam int LANE_W = 8;

   // RISC-V load/store width encodings (funct3)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ACCESS   = 2'd1,
      S_MERGE_WR = 2'd2,
      S_RESP     = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_lane_mux.sv
// Big-endian lane steering: load extract + sign/zero extend, and SB/SH lane merge into a word.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3_i access width, offset_i byte offset in word, rd_word_i word read from memory,
//        st_data_i right-justified store data, ld_data_o extended load result, merged_o RMW word.
module lsu_lane_mux
   import lsu_pkg::*;
(
   input  logic [2:0]          funct3_i,
   input  logic [1:0]          offset_i,
   input  logic [4*LANE_W-1:0] rd_word_i,
   input  logic [2*LANE_W-1:0] st_data_i,
   output logic [4*LANE_W-1:0] ld_data_o,
   output logic [4*LANE_W-1:0] merged_o
);

   localparam int WORD_W = 4 * LANE_W;

   logic [LANE_W-1:0]   byte_sel;
   logic [2*LANE_W-1:0] half_sel;

   // Byte offset 0 is the most significant lane.
   always_comb begin
      byte_sel = '0;
      case (offset_i)
         2'd0:    byte_sel = rd_word_i[4*LANE_W-1 -: LANE_W];
         2'd1:    byte_sel = rd_word_i[3*LANE_W-1 -: LANE_W];
         2'd2:    byte_sel = rd_word_i[2*LANE_W-1 -: LANE_W];
         default: byte_sel = rd_word_i[LANE_W-1:0];
      endcase
      half_sel = offset_i[1] ? rd_word_i[2*LANE_W-1:0] : rd_word_i[WORD_W-1 -: 2*LANE_W];
   end

   always_comb begin
      ld_data_o = rd_word_i;
      case (funct3_i)
         F3_B:    ld_data_o = {{(WORD_W-LANE_W){byte_sel[LANE_W-1]}}, byte_sel};
         F3_BU:   ld_data_o = {{(WORD_W-LANE_W){1'b0}}, byte_sel};
         F3_H:    ld_data_o = {{(WORD_W-2*LANE_W){half_sel[2*LANE_W-1]}}, half_sel};
         F3_HU:   ld_data_o = {{(WORD_W-2*LANE_W){1'b0}}, half_sel};
         default: ld_data_o = rd_word_i;
      endcase
   end

   // Only SB/SH reach the merge path, so funct3[1:0]==00 means byte, anything else halfword.
   always_comb begin
      merged_o = rd_word_i;
      if (funct3_i[1:0] == 2'b00) begin
         case (offset_i)
            2'd0:    merged_o[4*LANE_W-1 -: LANE_W] = st_data_i[LANE_W-1:0];
            2'd1:    merged_o[3*LANE_W-1 -: LANE_W] = st_data_i[LANE_W-1:0];
            2'd2:    merged_o[2*LANE_W-1 -: LANE_W] = st_data_i[LANE_W-1:0];
            default: merged_o[LANE_W-1:0]           = st_data_i[LANE_W-1:0];
         endcase
      end else if (offset_i[1]) begin
         merged_o[2*LANE_W-1:0] = st_data_i;
      end else begin
         merged_o[WORD_W-1 -: 2*LANE_W] = st_data_i;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator onto a word-only big-endian memory; SB/SH via read-modify-write.
// Latency accept->resp_valid: error 1, load/SW 2, SB/SH 3 cycles.
// Backpressure: req_ready high only in IDLE; one request in flight, requester holds until ready.
// Ports: req_* request side (valid/ready), resp_* one-cycle response pulse with held err/rdata,
//        mem_* word-aligned address, write word/strobe, combinational read word.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_BUS_WIDTH = 32,
   parameter int DATA_BUS_WIDTH = 32,
   parameter int MEM_BYTES      = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [2:0]                req_funct3,
   input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
   input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
   output logic                      resp_valid,
   output logic                      resp_err,
   output logic [DATA_BUS_WIDTH-1:0] resp_rdata,
   output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
   output logic [DATA_BUS_WIDTH-1:0] mem_write_data,
   output logic                      mem_write_en,
   input  logic [DATA_BUS_WIDTH-1:0] mem_read_data
);

   localparam int AW = ADDR_BUS_WIDTH;
   localparam int DW = DATA_BUS_WIDTH;

   lsu_state_t    state_q, state_d;
   logic          write_q, write_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] merged_q, merged_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic          f3_bad, misalign, out_of_range, req_err;
   logic          we_raw;
   logic [AW-1:0] word_addr;
   logic [DW-1:0] ld_data, merged_word;

   lsu_lane_mux u_lane_mux (
      .funct3_i  (funct3_q),
      .offset_i  (addr_q[1:0]),
      .rd_word_i (mem_read_data),
      .st_data_i (wdata_q[2*LANE_W-1:0]),
      .ld_data_o (ld_data),
      .merged_o  (merged_word)
   );

   // Request legality, evaluated on the live request in IDLE.
   always_comb begin
      f3_bad   = 1'b0;
      misalign = 1'b0;
      case (req_funct3)
         F3_B:    f3_bad = 1'b0;
         F3_BU:   f3_bad = req_write;
         F3_H:    misalign = req_addr[0];
         F3_HU: begin
            f3_bad   = req_write;
            misalign = req_addr[0];
         end
         F3_W:    misalign = |req_addr[1:0];
         default: f3_bad = 1'b1;
      endcase
   end

   assign out_of_range = (req_addr >= AW'(MEM_BYTES));
   assign req_err      = f3_bad | misalign | out_of_range;
   assign word_addr    = {addr_q[AW-1:2], 2'b00};

   always_comb begin
      state_d        = state_q;
      write_d        = write_q;
      funct3_d       = funct3_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      merged_d       = merged_q;
      rdata_d        = rdata_q;
      err_d          = err_q;
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      we_raw         = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_err) begin
                  // Rejected without touching memory; response fields update now since
                  // RESP follows in the very next cycle.
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            mem_addr = word_addr;
            if (!write_q) begin
               rdata_d = ld_data;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (funct3_q == F3_W) begin
               we_raw         = 1'b1;
               mem_write_data = wdata_q;
               rdata_d        = '0;
               err_d          = 1'b0;
               state_d        = S_RESP;
            end else begin
               merged_d = merged_word;
               state_d  = S_MERGE_WR;
            end
         end
         S_MERGE_WR: begin
            mem_addr       = word_addr;
            we_raw         = 1'b1;
            mem_write_data = merged_q;
            rdata_d        = '0;
            err_d          = 1'b0;
            state_d        = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A reset cycle must never commit a write, even mid-transaction.
   assign mem_write_en = we_raw & ~rst;
   assign resp_err     = err_q;
   assign resp_rdata   = rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         merged_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         merged_q <= merged_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

endmodule
